// File: rtl/bs_share_ctrl_pkg.sv
// Shared definitions for the barrel-shifter sharing controller:
// state encoding, default widths and requester IDs.
package bs_share_ctrl_pkg;

  localparam int SW_DEF = 26;
  localparam int EW_DEF = 8;

  localparam logic ID_ALIGN = 1'b0;
  localparam logic ID_NORM  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bs_share_ctrl_if.sv
// Request, shifter and response signals of bs_share_ctrl.
// The slave modport is the controller's view, master is the environment's.
interface bs_share_ctrl_if #(
  parameter int SW = 26,
  parameter int EW = 8
) ();

  logic          req0_valid_i;
  logic          req0_ready_o;
  logic [SW-1:0] req0_data_i;
  logic [EW-1:0] req0_shift_i;
  logic          req0_left_right_i;

  logic          req1_valid_i;
  logic          req1_ready_o;
  logic [SW-1:0] req1_data_i;
  logic [EW-1:0] req1_shift_i;
  logic          req1_left_right_i;

  logic          bs_load_o;
  logic [SW-1:0] bs_data_o;
  logic [EW-1:0] bs_shift_o;
  logic          bs_left_right_o;
  logic [SW-1:0] bs_result_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_id_o;
  logic [SW-1:0] rsp_data_o;

  modport slave (
    input  req0_valid_i, req0_data_i, req0_shift_i, req0_left_right_i,
    output req0_ready_o,
    input  req1_valid_i, req1_data_i, req1_shift_i, req1_left_right_i,
    output req1_ready_o,
    output bs_load_o, bs_data_o, bs_shift_o, bs_left_right_o,
    input  bs_result_i,
    output rsp_valid_o, rsp_id_o, rsp_data_o,
    input  rsp_ready_i
  );

  modport master (
    output req0_valid_i, req0_data_i, req0_shift_i, req0_left_right_i,
    input  req0_ready_o,
    output req1_valid_i, req1_data_i, req1_shift_i, req1_left_right_i,
    input  req1_ready_o,
    input  bs_load_o, bs_data_o, bs_shift_o, bs_left_right_o,
    output bs_result_i,
    input  rsp_valid_o, rsp_id_o, rsp_data_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/bs_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from a valid pair,
// favouring the port not granted last; history moves only on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_r;

  // Grant: a lone valid wins outright, a tie goes to the other port
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

  // Grant history; reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (advance) begin
      last_grant_r <= grant[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/bs_share_ctrl.sv
// Shares one registered barrel shifter between the alignment (port 0) and
// normalization (port 1) stages: arbitrate, latch operands, load, respond.
module bs_share_ctrl
  import bs_share_ctrl_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  bs_share_ctrl_if.slave bus
);

  localparam logic [EW-1:0] SHIFT_MAX = EW'(SW);

  state_e        state_r;
  logic          load_r;
  logic          rsp_valid_r;
  logic [SW-1:0] data_r;
  logic [EW-1:0] shift_r;
  logic          lr_r;
  logic          id_r;

  logic [1:0]    valid_s;
  logic [1:0]    grant_s;
  logic          idle_s;
  logic          accept_s;
  logic [SW-1:0] sel_data_s;
  logic [EW-1:0] sel_shift_raw_s;
  logic [EW-1:0] sel_shift_s;
  logic          sel_lr_s;

  assign valid_s  = {bus.req1_valid_i, bus.req0_valid_i};
  assign idle_s   = (state_r == ST_IDLE);
  assign accept_s = idle_s & (valid_s != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_s),
    .advance (accept_s),
    .grant   (grant_s)
  );

  assign bus.req0_ready_o = idle_s & grant_s[0];
  assign bus.req1_ready_o = idle_s & grant_s[1];

  // Winning operand set; shifts beyond the mantissa width saturate at SW
  always_comb begin
    sel_data_s      = bus.req0_data_i;
    sel_shift_raw_s = bus.req0_shift_i;
    sel_lr_s        = bus.req0_left_right_i;
    sel_shift_s     = {EW{1'b0}};
    if (grant_s[1]) begin
      sel_data_s      = bus.req1_data_i;
      sel_shift_raw_s = bus.req1_shift_i;
      sel_lr_s        = bus.req1_left_right_i;
    end else begin
      sel_data_s      = bus.req0_data_i;
      sel_shift_raw_s = bus.req0_shift_i;
      sel_lr_s        = bus.req0_left_right_i;
    end
    if (sel_shift_raw_s > SHIFT_MAX) begin
      sel_shift_s = SHIFT_MAX;
    end else begin
      sel_shift_s = sel_shift_raw_s;
    end
  end

  // Controller FSM with operand latches and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      load_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      data_r      <= {SW{1'b0}};
      shift_r     <= {EW{1'b0}};
      lr_r        <= 1'b0;
      id_r        <= ID_ALIGN;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            data_r  <= sel_data_s;
            shift_r <= sel_shift_s;
            lr_r    <= sel_lr_s;
            id_r    <= grant_s[1] ? ID_NORM : ID_ALIGN;
            load_r  <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          load_r      <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          load_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bs_load_o       = load_r;
  assign bus.bs_data_o       = data_r;
  assign bus.bs_shift_o      = shift_r;
  assign bus.bs_left_right_o = lr_r;

  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_id_o    = id_r;
  assign bus.rsp_data_o  = bus.bs_result_i;

endmodule

// File: tb/tb_bs_share_ctrl.sv
// Self-checking bench for bs_share_ctrl: directed scenarios plus random
// traffic against a transaction-level reference model and a shifter model.
module tb_bs_share_ctrl;
  import bs_share_ctrl_pkg::*;

  localparam int SW = SW_DEF;
  localparam int EW = EW_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bs_share_ctrl_if #(.SW(SW), .EW(EW)) bif ();

  bs_share_ctrl #(.SW(SW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Stand-in for the parent's barrel shifter: 1 = left, 0 = right, zero fill
  logic [SW-1:0] shreg;
  always_ff @(posedge clk) begin
    if (rst) shreg <= '0;
    else if (bif.bs_load_o)
      shreg <= bif.bs_left_right_o ? (bif.bs_data_o << bif.bs_shift_o)
                                   : (bif.bs_data_o >> bif.bs_shift_o);
  end
  assign bif.bs_result_i = shreg;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending requests per port (held valid until accepted)
  bit            pv [2];
  logic [SW-1:0] pd [2];
  int            ps [2];
  bit            pl [2];

  // Reference model: outstanding transaction and its age in cycles
  int            last_g = 1;
  bit            busy   = 1'b0;
  int            age    = 0;
  logic [SW-1:0] m_data = '0;
  int            m_shift = 0;
  bit            m_lr  = 1'b0;
  bit            m_id  = 1'b0;
  logic [SW-1:0] m_res = '0;

  bit            gen_en   = 1'b0;
  int            req_rate = 50;
  int            rdy_rate = 100;
  logic [SW-1:0] last_rsp = '0;
  int            grants[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] ref_shift(input logic [SW-1:0] d, input int s, input bit l);
    int c;
    c = (s > SW) ? SW : s;
    return l ? (d << c) : (d >> c);
  endfunction

  task automatic set_req(input int p, input logic [SW-1:0] d, input int s, input bit l);
    pv[p] = 1'b1; pd[p] = d; ps[p] = s; pl[p] = l;
  endtask

  // One clock cycle: drive at negedge, check outputs, predict the next edge
  task automatic step(input bit do_rst);
    int g;
    if (gen_en) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom_range(0, 99) < req_rate)) begin
          set_req(p, SW'($urandom),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30),
                  bit'($urandom_range(0, 1)));
        end
      end
    end
    bif.req0_valid_i      = pv[0];
    bif.req0_data_i       = pd[0];
    bif.req0_shift_i      = EW'(ps[0]);
    bif.req0_left_right_i = pl[0];
    bif.req1_valid_i      = pv[1];
    bif.req1_data_i       = pd[1];
    bif.req1_shift_i      = EW'(ps[1]);
    bif.req1_left_right_i = pl[1];
    bif.rsp_ready_i       = ($urandom_range(0, 99) < rdy_rate);
    rst = do_rst;
    #1;
    g = -1;
    if (!busy) begin
      if (pv[0] && pv[1]) g = (last_g == 0) ? 1 : 0;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
    end
    check_eq("req0_ready", 32'(bif.req0_ready_o), 32'(g == 0));
    check_eq("req1_ready", 32'(bif.req1_ready_o), 32'(g == 1));
    check_eq("bs_load", 32'(bif.bs_load_o), 32'(busy && age == 1));
    check_eq("rsp_valid", 32'(bif.rsp_valid_o), 32'(busy && age >= 2));
    check_eq("bs_data", 32'(bif.bs_data_o), 32'(m_data));
    check_eq("bs_shift", 32'(bif.bs_shift_o), 32'(m_shift));
    check_eq("bs_lr", 32'(bif.bs_left_right_o), 32'(m_lr));
    check_eq("rsp_id", 32'(bif.rsp_id_o), 32'(m_id));
    check_eq("rsp_data", 32'(bif.rsp_data_o), 32'(m_res));
    if (bif.rsp_valid_o && bif.rsp_ready_i) last_rsp = bif.rsp_data_o;
    if (do_rst) begin
      busy = 1'b0; age = 0; last_g = 1;
      m_data = '0; m_shift = 0; m_lr = 1'b0; m_id = 1'b0; m_res = '0;
    end else if (busy) begin
      if (age >= 2 && bif.rsp_ready_i) begin
        busy = 1'b0;
      end else begin
        if (age == 1) m_res = ref_shift(m_data, m_shift, m_lr);
        age++;
      end
    end else if (g >= 0) begin
      busy = 1'b1; age = 1;
      m_data = pd[g]; m_shift = (ps[g] > SW) ? SW : ps[g]; m_lr = pl[g]; m_id = bit'(g);
      last_g = g; pv[g] = 1'b0;
      grants.push_back(g);
    end
    @(negedge clk);
  endtask

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    pd[0] = '0; pd[1] = '0; ps[0] = 0; ps[1] = 0; pl[0] = 1'b0; pl[1] = 1'b0;
    bif.req0_valid_i = 1'b0; bif.req0_data_i = '0; bif.req0_shift_i = '0; bif.req0_left_right_i = 1'b0;
    bif.req1_valid_i = 1'b0; bif.req1_data_i = '0; bif.req1_shift_i = '0; bif.req1_left_right_i = 1'b0;
    bif.rsp_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values, then a single alignment request shifted right by 3
    step(1'b0);
    set_req(0, 26'h2000000, 3, 1'b0);
    repeat (4) step(1'b0);
    check_eq("single_rsp", 32'(last_rsp), 32'h0400000);

    // Tie after reset: port 0 first, then strict alternation
    step(1'b1);
    grants.delete();
    for (int i = 0; i < 40 && grants.size() < 6; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p]) set_req(p, SW'($urandom), $urandom_range(0, 26), bit'($urandom_range(0, 1)));
      step(1'b0);
    end
    check_eq("tie_ops", 32'(grants.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check_eq("tie_order", 32'(grants[i]), 32'(i % 2));
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (4) step(1'b0);

    // Back-pressure: response held for 5 cycles
    rdy_rate = 0;
    set_req(0, 26'h1234567, 5, 1'b1);
    repeat (7) step(1'b0);
    rdy_rate = 100;
    repeat (2) step(1'b0);

    // Shift clamp on the normalization port
    set_req(1, 26'h3ffffff, 40, 1'b1);
    last_rsp = 26'h1;
    repeat (4) step(1'b0);
    check_eq("clamp_rsp", 32'(last_rsp), 32'h0);

    // Reset in LOAD, then a normal request
    set_req(0, 26'h0abcdef, 2, 1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    set_req(1, 26'h0000f00, 4, 1'b1);
    repeat (4) step(1'b0);
    check_eq("after_rst_rsp", 32'(last_rsp), 32'h000f000);

    // Port 1 arrives while port 0 is in LOAD
    set_req(0, 26'h0000100, 1, 1'b1);
    step(1'b0);
    set_req(1, 26'h0000800, 3, 1'b0);
    repeat (6) step(1'b0);
    check_eq("busy_rsp", 32'(last_rsp), 32'h0000100);

    // Random traffic with occasional resets
    gen_en   = 1'b1;
    req_rate = 40;
    rdy_rate = 60;
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
